// File: rtl/gfx_fetch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : gfx_fetch_arbiter
//  Purpose  : Collects toggle-handshake ROM fetch requests from CHANNELS
//             tilemap/sprite layer engines and issues them one at a time on
//             a single toggle-handshake ROM port. Each returned word is
//             registered onto load_data, optionally nibble-reversed for a
//             horizontal flip, and marked with a one-cycle per-channel
//             ch_load strobe.
//  Build option:
//             GFX_FETCH_RR_EN - when defined, arbitration is round-robin
//             starting after the last granted channel. When undefined,
//             arbitration is fixed priority in PRIO_ORDER entry order.
//  Ports    : clk          - sole clock, rising edge
//             resetn       - asynchronous active-low reset
//             ch_req  [C]  - per-channel request toggle
//             ch_ack  [C]  - per-channel acknowledge toggle
//             ch_addr [C*A]- packed per-channel ROM word address
//             ch_flip [C]  - per-channel horizontal flip (nibble reverse)
//             ch_load [C]  - one-hot, one-cycle load strobe
//             load_data    - registered fetched word
//             rom_address  - ROM word address (latched at grant)
//             rom_req      - ROM request toggle
//             rom_ack      - ROM acknowledge toggle
//             rom_data     - ROM read data, valid when rom_ack == rom_req
//  Revision : 1.0 - initial release
// ============================================================================
module gfx_fetch_arbiter #(
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 22,
    parameter int DATA_W   = 64,
    parameter logic [CHANNELS*$clog2(CHANNELS)-1:0] PRIO_ORDER = {2'd2, 2'd1, 2'd3, 2'd0}
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [CHANNELS-1:0]          ch_req,
    output logic [CHANNELS-1:0]          ch_ack,
    input  logic [CHANNELS*ADDR_W-1:0]   ch_addr,
    input  logic [CHANNELS-1:0]          ch_flip,
    output logic [CHANNELS-1:0]          ch_load,
    output logic [DATA_W-1:0]            load_data,
    output logic [ADDR_W-1:0]            rom_address,
    output logic                         rom_req,
    input  logic                         rom_ack,
    input  logic [DATA_W-1:0]            rom_data
);

    localparam int IW  = $clog2(CHANNELS);
    localparam int NIB = DATA_W / 4;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                 state_q;
    logic [CHANNELS-1:0]    ch_ack_q;
    logic [CHANNELS-1:0]    ch_load_q;
    logic [DATA_W-1:0]      load_data_q;
    logic [ADDR_W-1:0]      rom_address_q;
    logic                   rom_req_q;
    logic                   flip_q;
    logic [IW-1:0]          grant_q;

    logic [CHANNELS-1:0]    pending;
    logic                   rom_idle;
    logic [IW-1:0]          win_d;
    logic [ADDR_W-1:0]      addr_sel;
    logic [DATA_W-1:0]      rom_data_rev;
    logic [DATA_W-1:0]      load_data_d;

    // A channel is waiting whenever its two toggles disagree.
    assign pending  = ch_req ^ ch_ack_q;
    assign rom_idle = (rom_req_q == rom_ack);

`ifdef GFX_FETCH_RR_EN
    logic [IW-1:0] last_q;

    // Scan last+1 .. last+CHANNELS; iterating from the far end lets the
    // nearest pending channel overwrite the result last.
    always_comb begin
        logic [IW-1:0] idx;
        win_d = '0;
        idx   = '0;
        for (int i = CHANNELS; i >= 1; i--) begin
            idx = IW'((int'(last_q) + i) % CHANNELS);
            if (pending[idx]) begin
                win_d = idx;
            end
        end
    end
`else
    // Walk the priority table from lowest to highest so the highest-priority
    // pending channel is the final assignment.
    always_comb begin
        win_d = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (pending[PRIO_ORDER[k*IW +: IW]]) begin
                win_d = PRIO_ORDER[k*IW +: IW];
            end
        end
    end
`endif

    assign addr_sel = ch_addr[win_d*ADDR_W +: ADDR_W];

    // Pixel order reversal for horizontally flipped tiles/sprites.
    for (genvar j = 0; j < NIB; j++) begin : g_nib_rev
        assign rom_data_rev[j*4 +: 4] = rom_data[(NIB-1-j)*4 +: 4];
    end

    assign load_data_d = flip_q ? rom_data_rev : rom_data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            ch_ack_q      <= '0;
            ch_load_q     <= '0;
            load_data_q   <= '0;
            rom_address_q <= '0;
            rom_req_q     <= 1'b0;
            flip_q        <= 1'b0;
            grant_q       <= '0;
`ifdef GFX_FETCH_RR_EN
            last_q        <= IW'(CHANNELS - 1);
`endif
        end else begin
            // The load strobe is only ever a single-cycle pulse.
            ch_load_q <= '0;
            case (state_q)
                S_IDLE: begin
                    // Never issue while the ROM port is still mismatched.
                    if ((|pending) && rom_idle) begin
                        grant_q       <= win_d;
                        rom_address_q <= addr_sel;
                        flip_q        <= ch_flip[win_d];
                        rom_req_q     <= ~rom_req_q;
                        state_q       <= S_BUSY;
`ifdef GFX_FETCH_RR_EN
                        last_q        <= win_d;
`endif
                    end
                end
                S_BUSY: begin
                    if (rom_idle) begin
                        load_data_q        <= load_data_d;
                        ch_load_q[grant_q] <= 1'b1;
                        ch_ack_q[grant_q]  <= ~ch_ack_q[grant_q];
                        state_q            <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ch_ack      = ch_ack_q;
    assign ch_load     = ch_load_q;
    assign load_data   = load_data_q;
    assign rom_address = rom_address_q;
    assign rom_req     = rom_req_q;

endmodule
`default_nettype wire

// File: tb/tb_gfx_fetch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gfx_fetch_arbiter
//  Purpose  : Directed self-checking bench for gfx_fetch_arbiter. Expected
//             loads are queued when a request is driven and compared when the
//             DUT raises ch_load. A behavioural ROM with programmable latency
//             answers the ROM port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gfx_fetch_arbiter;

    localparam int CH = 4;
    localparam int AW = 22;
    localparam int DW = 64;

    logic              clk = 1'b0;
    logic              resetn;
    logic [CH-1:0]     ch_req;
    logic [CH-1:0]     ch_ack;
    logic [CH*AW-1:0]  ch_addr;
    logic [CH-1:0]     ch_flip;
    logic [CH-1:0]     ch_load;
    logic [DW-1:0]     load_data;
    logic [AW-1:0]     rom_address;
    logic              rom_req;
    logic              rom_ack;
    logic [DW-1:0]     rom_data;

    int checks = 0;
    int errors = 0;
    int rom_lat = 1;
    int req_toggles = 0;
    int cyc = 0;
    int last_tog = -100;
    logic prev_req = 1'b0;
    int t0;
    logic [AW-1:0] a0;
    int served;
    int nloop;

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    gfx_fetch_arbiter dut (
        .clk         (clk),
        .resetn      (resetn),
        .ch_req      (ch_req),
        .ch_ack      (ch_ack),
        .ch_addr     (ch_addr),
        .ch_flip     (ch_flip),
        .ch_load     (ch_load),
        .load_data   (load_data),
        .rom_address (rom_address),
        .rom_req     (rom_req),
        .rom_ack     (rom_ack),
        .rom_data    (rom_data)
    );

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        return 64'h0123456789ABCDEF + {42'd0, a} - 64'h12345;
    endfunction

    function automatic logic [DW-1:0] nibrev(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = '0;
        for (int j = 0; j < DW/4; j++) r[j*4 +: 4] = d[(DW/4-1-j)*4 +: 4];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic request(input int ch, input logic [AW-1:0] a, input logic f);
        exp_t e;
        ch_addr[ch*AW +: AW] = a;
        ch_flip[ch]          = f;
        ch_req[ch]           = ~ch_req[ch];
        e.ch   = ch;
        e.data = f ? nibrev(rom_fn(a)) : rom_fn(a);
        sb_q.push_back(e);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (rom_req === rom_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(rom_req !== rom_ack), 64'd1);
    endtask

    // Behavioural ROM: acks after rom_lat+1 checks of a mismatched port.
    initial begin
        int cnt = 0;
        rom_ack  = 1'b0;
        rom_data = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!resetn) begin
                rom_ack = 1'b0;
                cnt     = 0;
            end else if (rom_req != rom_ack) begin
                cnt++;
                if (cnt > rom_lat) begin
                    rom_ack  = rom_req;
                    rom_data = rom_fn(rom_address);
                    cnt      = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Output monitor: rom_req spacing and scoreboard comparison of loads.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!resetn) begin
                prev_req = rom_req;
            end else begin
                if (rom_req !== prev_req) begin
                    req_toggles++;
                    chk("rom_req_spacing", 64'((cyc - last_tog) >= 2), 64'd1);
                    last_tog = cyc;
                    prev_req = rom_req;
                end
                if (ch_load !== '0) begin
                    chk("ch_load_onehot", 64'($onehot(ch_load)), 64'd1);
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL unexpected_load observed=%b expected=none", ch_load);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("load_channel", 64'(ch_load), 64'(4'b0001 << e.ch));
                        chk("load_data", load_data, e.data);
                        chk("ack_toggled", 64'(ch_ack[e.ch]), 64'(ch_req[e.ch]));
                    end
                end
            end
        end
    end

    initial begin
        resetn  = 1'b0;
        ch_req  = '0;
        ch_flip = '0;
        ch_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_rom_req",     64'(rom_req),     64'd0);
        chk("rst_rom_address", 64'(rom_address), 64'd0);
        chk("rst_ch_ack",      64'(ch_ack),      64'd0);
        chk("rst_ch_load",     64'(ch_load),     64'd0);
        chk("rst_load_data",   load_data,        64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // Single request, then check exact issue timing.
        @(posedge clk); #1;
        request(1, 22'h12345, 1'b0);
        @(negedge clk);
        chk("req_not_yet", 64'(rom_req), 64'd0);
        @(negedge clk);
        chk("req_toggled", 64'(rom_req), 64'd1);
        chk("rom_address", 64'(rom_address), 64'h12345);
        wait_done("single_done");
        chk("single_ch_ack", 64'(ch_ack), 64'b0010);
        repeat (3) @(negedge clk);
        chk("load_hold", load_data, 64'h0123456789ABCDEF);
        chk("load_idle", 64'(ch_load), 64'd0);

        // Flip on the same address.
        @(posedge clk); #1;
        request(1, 22'h12345, 1'b1);
        wait_done("flip_done");
        chk("flip_data", load_data, 64'hFEDCBA9876543210);
        chk("flip_ch_ack", 64'(ch_ack), 64'd0);

`ifndef GFX_FETCH_RR_EN
        // All four at once: expected grant order 0,3,1,2.
        t0 = req_toggles;
        @(posedge clk); #1;
        request(0, 22'h00100, 1'b0);
        request(3, 22'h00300, 1'b1);
        request(1, 22'h00110, 1'b1);
        request(2, 22'h00200, 1'b0);
        wait_done("prio_done");
        chk("prio_toggles", 64'(req_toggles - t0), 64'd4);
`else
        // Fresh pointer, then everyone re-requests on ack for 8 fetches.
        @(posedge clk); #1;
        resetn = 1'b0;
        ch_req = '0;
        sb_q.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        request(0, 22'h00100, 1'b0);
        request(1, 22'h00110, 1'b1);
        request(2, 22'h00200, 1'b0);
        request(3, 22'h00300, 1'b1);
        served = 0;
        nloop  = 0;
        while (served < 8 && nloop < 400) begin
            @(negedge clk);
            nloop++;
            if (ch_load != '0) begin
                served++;
                if (served <= 4) begin
                    for (int c = 0; c < CH; c++) begin
                        if (ch_load[c]) begin
                            @(posedge clk); #1;
                            request(c, AW'(22'h01000 + c), c[0]);
                        end
                    end
                end
            end
        end
        chk("rr_served", 64'(served), 64'd8);
        wait_done("rr_done");
`endif

        // ROM stall: address/flip changes after grant must not matter.
        rom_lat = 21;
        @(posedge clk); #1;
        request(2, 22'h2AAAA, 1'b1);
        wait_busy("stall_busy");
        t0 = req_toggles;
        a0 = rom_address;
        chk("stall_addr_latched", 64'(a0), 64'h2AAAA);
        @(posedge clk); #1;
        request(0, 22'h01234, 1'b0);
        repeat (19) begin
            @(posedge clk); #1;
            ch_addr[2*AW +: AW] = AW'($urandom);
            ch_flip[2]          = ~ch_flip[2];
        end
        @(negedge clk);
        chk("stall_no_toggle", 64'(req_toggles - t0), 64'd0);
        chk("stall_addr_stable", 64'(rom_address), 64'h2AAAA);
        wait_done("stall_done");
        rom_lat = 1;

        // Reset in the middle of a fetch.
        rom_lat = 5;
        @(posedge clk); #1;
        request(3, 22'h03333, 1'b0);
        wait_busy("midrst_busy");
        @(posedge clk); #1;
        resetn = 1'b0;
        ch_req = '0;
        sb_q.delete();
        @(negedge clk);
        chk("midrst_rom_req", 64'(rom_req), 64'd0);
        chk("midrst_ch_ack",  64'(ch_ack),  64'd0);
        chk("midrst_ch_load", 64'(ch_load), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (8) @(negedge clk);
        rom_lat = 1;
        @(posedge clk); #1;
        request(3, 22'h03333, 1'b1);
        wait_done("postrst_done");
        chk("postrst_ch_ack", 64'(ch_ack), 64'b1000);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gfx_fetch_arbiter.md
# gfx_fetch_arbiter

Parametrised N-channel graphics ROM fetch arbiter for tilemap and sprite layer engines. It collects toggle-handshake fetch requests from up to CHANNELS layer engines and issues them one at a time onto a single toggle-handshake ROM port. It returns each word as a registered, optionally nibble-reversed `load_data` with a one-cycle per-channel load strobe. Its place is between the layer shifters and the SDRAM/ROM controller.

## Interface
- `CHANNELS`, 4: number of requesting channels, 2..16.
- `ADDR_W`, 22: ROM word address width.
- `DATA_W`, 64: ROM data width; multiple of 4 (4-bit pixels).
- `PRIO_ORDER`, {2'd2,2'd1,2'd3,2'd0}: fixed-priority table, `IW=$clog2(CHANNELS)` bits per entry.
  - Entry k (bits `[k*IW +: IW]`) is the channel with k-th highest priority.
  - Default order is 0,3,1,2.
- `clk` in 1: sole clock. All logic is on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `ch_req` in CHANNELS: per-channel request toggle.
- `ch_ack` out CHANNELS: per-channel acknowledge toggle.
- `ch_addr` in CHANNELS*ADDR_W: packed per-channel ROM address. Channel i is `[i*ADDR_W +: ADDR_W]`.
- `ch_flip` in CHANNELS: per-channel horizontal flip; reverses pixel nibbles.
- `ch_load` out CHANNELS: one-hot, one-cycle strobe marking `load_data` valid for that channel.
- `load_data` out DATA_W: registered fetched word.
- `rom_address` out ADDR_W: ROM address.
- `rom_req` out 1: ROM request toggle.
- `rom_ack` in 1: ROM acknowledge toggle. Equal to `rom_req` means the ROM is idle or done.
- `rom_data` in DATA_W: ROM read data, valid when `rom_ack==rom_req`.

## Operation
- Pending channel: `pending[i] = ch_req[i] ^ ch_ack[i]`.
- State IDLE:
  - Condition: any pending channel and `rom_req==rom_ack`.
  - Select winner g.
  - Latch `rom_address<=ch_addr[g]` and `flip_q<=ch_flip[g]`.
  - Set `grant<=g` and toggle `rom_req`.
  - Go to BUSY.
- State BUSY:
  - When `rom_req==rom_ack`:
    - `load_data <= flip_q ? nibble_reverse(rom_data) : rom_data`.
    - `ch_load[grant]<=1` for one cycle.
    - `ch_ack[grant]<=~ch_ack[grant]`.
  - Go to IDLE.
- `nibble_reverse`: output nibble j equals input nibble (DATA_W/4-1-j).
- Address and flip are sampled only at grant. Changes afterwards do not affect an in-flight fetch.
- Channel rule: a channel toggles `ch_req` only when `ch_req==ch_ack`. A second toggle while pending cancels the request.
  - If the cancel happens before grant, no fetch occurs.
  - If the cancel happens after grant, the fetch completes and `ch_ack` toggles, so the channel then shows pending again. The channel must not do this.
- `ch_load` is all-zero except in the single cycle after completion.
- `load_data` holds its value until the next completion.

## Timing
- Reset values:
  - Outputs: `rom_req=0`, `rom_address=0`, `ch_ack=0`, `ch_load=0`, `load_data=0`.
  - Internal: state IDLE, `grant=0`, `flip_q=0`, round-robin pointer `last=CHANNELS-1`.
- The ROM controller shares `resetn`. Reset mid-fetch abandons the fetch; no load strobe is issued.
- Request toggle seen in cycle N (IDLE, ROM idle): `rom_req` toggles at edge N+1.
- `rom_ack` matches in cycle M: `ch_load`, `load_data` and `ch_ack` update at edge M+1.
- The earliest next grant is evaluated in cycle M+1, so the minimum spacing between `rom_req` toggles is 2 cycles.
- Minimum request-to-load latency is 3 cycles with a zero-wait ROM (ack in the cycle after the req toggle).
- The arbiter never issues while `rom_req!=rom_ack`, even in IDLE (e.g. after an external mismatch). It waits.
- Simultaneous events:
  - A new toggle on the granted channel in the completion cycle is seen as pending in the next IDLE cycle.
  - Requests from other channels during BUSY wait for IDLE.

## Configuration
- `GFX_FETCH_RR_EN` defined: round-robin arbitration.
  - Winner is the first pending channel scanning `last+1, last+2, ...` modulo CHANNELS.
  - `last<=g` on each grant.
  - `PRIO_ORDER` is ignored.
- `GFX_FETCH_RR_EN` undefined: fixed priority.
  - Winner is the first pending channel in `PRIO_ORDER` entry order 0..CHANNELS-1.
  - The `last` register is not built.

## Test plan
- Reset and single request:
  - Stimulus: hold `resetn=0`, then release. Toggle `ch_req[1]` with `ch_addr[1]=22'h12345`. ROM acks one cycle after the req toggle with `rom_data=64'h0123456789ABCDEF`.
  - Required: all outputs 0 during reset; `rom_req` toggles at N+1; `rom_address=22'h12345`; `ch_load=4'b0010` for one cycle; `load_data=64'h0123456789ABCDEF`; `ch_ack[1]=1`.
- Flip:
  - Stimulus: same as above with `ch_flip[1]=1`.
  - Required: `load_data=64'hFEDCBA9876543210`.
- Fixed priority (macro undefined):
  - Stimulus: toggle all four `ch_req` in the same cycle.
  - Required: grant order 0,3,1,2; four one-hot `ch_load` strobes; `rom_req` toggles spaced at least 2 cycles apart.
- Round-robin (macro defined):
  - Stimulus: keep all four channels re-requesting on each ack for 8 fetches.
  - Required: grant order 0,1,2,3,0,1,2,3.
- ROM stall:
  - Stimulus: hold `rom_ack` mismatched for 20 cycles while `ch_addr` and `ch_flip` change.
  - Required: no further `rom_req` toggle; `rom_address` stable; data captured using the flip value sampled at grant.
- Reset mid-fetch:
  - Stimulus: assert `resetn=0` while BUSY, then release.
  - Required: no `ch_load` strobe; `rom_req=0`, `ch_ack=0`; the next request is serviced normally.
